// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV) for the execution stage.
// Moves one bit position per clock under a start/busy/done handshake.
module shift_right_seq #(
  parameter int unsigned B  = 32,
  parameter int unsigned SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [B-1:0]  shift_in,
  input  logic [SW-1:0] shamt,
  input  logic          arith,
  output logic          busy,
  output logic          done,
  output logic [B-1:0]  shift_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [B-1:0]  data_q,  data_d;
  logic [SW-1:0] cnt_q,   cnt_d;
  logic          mode_q,  mode_d;
  logic [B-1:0]  out_q,   out_d;

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath update; shamt >= B saturates by plain continued shifting.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = shift_in;
          cnt_d   = shamt;
          mode_d  = arith;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {mode_q & data_q[B-1], data_q[B-1:1]};
          cnt_d  = cnt_q - SW'(1);
        end else begin
          out_d   = data_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode the state register only, never the inputs.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign shift_out = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomized scoreboard bench for shift_right_seq against an arithmetic reference model.
module tb_shift_right_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] shift_in;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] shift_out;

  shift_right_seq #(.B(32), .SW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .shift_in  (shift_in),
    .shamt     (shamt),
    .arith     (arith),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out)
  );

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] last_out = '0;
  logic        prev_rst = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int n, input logic a);
    if (a) return 32'($signed(x) >>> n);
    return x >> n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks result, timing and output stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pending request (t=%0t)", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", shift_out, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (prev_rst) begin
        chk("out_stable", shift_out, last_out);
      end
    end
    last_out = shift_out;
    prev_rst = rst_n;
  end

  // Wait for IDLE, present one request for one edge, then scramble operands.
  task automatic issue(input logic [31:0] x, input logic [4:0] n, input logic a);
    int w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      chk("idle_timeout", 32'(busy), 32'(0));
      return;
    end
    start = 1'b1; shift_in = x; shamt = n; arith = a;
    q.push_back('{res: ref_shift(x, int'(n), a), due: cyc + int'(n) + 2});
    @(posedge clk);
    #1;
    start = 1'b0; shift_in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk(nm, 32'(q.size()), 32'(0));
  endtask

  // Start held high: one accept per IDLE cycle, done spacing shamt+3, one idle cycle between.
  task automatic b2b(input logic [31:0] x, input logic [4:0] n, input logic a, input int k);
    int seen = 0;
    int last = 0;
    int gap  = 0;
    int w    = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1; shift_in = x; shamt = n; arith = a;
    w = 0;
    while (seen < k && w < 2000) begin
      if (!busy) begin
        q.push_back('{res: ref_shift(x, int'(n), a), due: cyc + int'(n) + 2});
        if (seen > 0) gap++;
      end
      if (done) begin
        if (seen > 0) begin
          chk("b2b_period", 32'(cyc - last), 32'(int'(n) + 3));
          chk("b2b_idle_gap", 32'(gap), 32'(1));
        end
        last = cyc;
        gap  = 0;
        seen++;
      end
      if (seen < k) @(negedge clk);
      w++;
    end
    start = 1'b0;
    chk("b2b_count", 32'(seen), 32'(k));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; shift_in = '0; shamt = '0; arith = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_out", shift_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(32'hF000_0010, 5'd4, 1'b0);
    drain("drain_srl");
    chk("srl_value", shift_out, 32'h0F00_0001);
    issue(32'h8000_0000, 5'd31, 1'b1);
    drain("drain_sra");
    chk("sra_value", shift_out, 32'hFFFF_FFFF);
    issue(32'h1234_5678, 5'd0, 1'b0);
    drain("drain_zero");
    chk("zero_value", shift_out, 32'h1234_5678);
    issue(32'h7FFF_FFFF, 5'd31, 1'b1);
    issue(32'h8000_0001, 5'd31, 1'b0);
    drain("drain_edges");

    // Start pulses while busy must be ignored
    issue(32'hCAFE_BABE, 5'd10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_high", 32'(busy), 32'(1));
      start = 1'b1; shift_in = 32'hFFFF_0000; shamt = 5'd1; arith = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    drain("drain_ignore");
    chk("ignore_value", shift_out, 32'hFFF2_BFAE);

    b2b(32'h9000_00F0, 5'd3, 1'b1, 3);
    drain("drain_b2b");
    b2b(32'h0000_FFFF, 5'd0, 1'b0, 3);
    drain("drain_b2b0");

    // Random traffic with spurious starts while busy
    for (int i = 0; i < 150; i++) begin
      issue($urandom, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        if (busy) begin
          start = 1'b1; shift_in = $urandom; shamt = 5'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    drain("drain_rand");

    // Reset in the middle of a long shift abandons it immediately
    issue(32'hFFFF_FFFF, 5'd31, 1'b1);
    drain("drain_pre_rst");
    issue(32'hA5A5_A5A5, 5'd20, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_out", shift_out, 32'h0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'(0));
    chk("post_rst_out", shift_out, 32'h0);

    issue(32'h8421_0000, 5'd8, 1'b1);
    drain("drain_final");
    chk("final_value", shift_out, 32'hFF84_2100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
